// File: rtl/nios2_mul_combine.sv
// -----------------------------------------------------------------------------
// nios2_mul_combine
//
// Two-stage partial-product combiner for the Nios II multiply path. It sits
// directly behind the four-cell 16x16 multiplier array and folds the four
// registered 32-bit partial products into the exact 64-bit product for any
// combination of operand signedness. It then returns either the low word
// (MUL) or the high word (MULXSS/MULXSU/MULXUU) together with the
// destination register number. It accepts one multiply per enabled cycle.
//
//   product = {p4, p1} + (ext(p2) + ext(p3)) << 16      (mod 2^64)
//
// Stage A : 34-bit signed cross-term add (p2 + p3), p1/p4 and control captured
// Stage W : 64-bit final add and result-word select
//
// Ports
//   clk                   core clock, all state on the rising edge
//   reset                 asynchronous, active-high, clears every register
//   M_en                  pipeline advance enable (0 = hold every register)
//   flush                 synchronous kill of all in-flight multiplies
//   M_mul_valid           p1..p4 carry a multiply this cycle
//   M_mul_src1_signed     src1 is signed
//   M_mul_src2_signed     src2 is signed
//   M_mul_hi              1 = return product[63:32], 0 = product[31:0]
//   M_dst_regnum          destination register number
//   M_mul_cell_p1..p4     partial products from the multiplier array
//   W_mul_valid           W_mul_result / W_dst_regnum are valid
//   W_mul_result          selected 32-bit product word
//   W_mul_product         full 64-bit product (debug / trace)
//   W_dst_regnum          destination register number
//   mul_busy              a multiply is in flight in stage A or W
// -----------------------------------------------------------------------------
module nios2_mul_combine #(
    parameter int REGNUM_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                M_en,
    input  logic                flush,
    input  logic                M_mul_valid,
    input  logic                M_mul_src1_signed,
    input  logic                M_mul_src2_signed,
    input  logic                M_mul_hi,
    input  logic [REGNUM_W-1:0] M_dst_regnum,
    input  logic [31:0]         M_mul_cell_p1,
    input  logic [31:0]         M_mul_cell_p2,
    input  logic [31:0]         M_mul_cell_p3,
    input  logic [31:0]         M_mul_cell_p4,
    output logic                W_mul_valid,
    output logic [31:0]         W_mul_result,
    output logic [63:0]         W_mul_product,
    output logic [REGNUM_W-1:0] W_dst_regnum,
    output logic                mul_busy
);

    // ---------------------------------------------------------------------
    // Stage A registers
    // ---------------------------------------------------------------------
    logic                a_valid_q;
    logic [33:0]         a_cross_q;
    logic [31:0]         a_p1_q;
    logic [31:0]         a_p4_q;
    logic                a_hi_q;
    logic [REGNUM_W-1:0] a_dst_q;

    // ---------------------------------------------------------------------
    // Stage W registers
    // ---------------------------------------------------------------------
    logic                w_valid_q;
    logic [63:0]         w_product_q;
    logic [31:0]         w_result_q;
    logic [REGNUM_W-1:0] w_dst_q;

    // ---------------------------------------------------------------------
    // Next-state values
    // ---------------------------------------------------------------------
    logic [33:0]         a_cross_d;
    logic [63:0]         w_product_d;
    logic [31:0]         w_result_d;

    // Stage A: the two cross terms each carry the signedness of the operand
    // that contributes its upper half (p2 uses src2[31:16], p3 uses
    // src1[31:16]). Two guard bits keep the sum of two 32-bit values exact
    // in every signed/unsigned mix.
    always_comb begin
        a_cross_d = {{2{M_mul_cell_p2[31] & M_mul_src2_signed}}, M_mul_cell_p2}
                  + {{2{M_mul_cell_p3[31] & M_mul_src1_signed}}, M_mul_cell_p3};
    end

    // Stage W: p4 occupies bits [63:32] in full, so its sign extension lands
    // above bit 63 and vanishes modulo 2^64. For that reason no p4
    // signedness flag travels down the pipe. The uu value 0xFFFE0001 is
    // therefore placed as-is. The cross term is sign-extended from 34 bits
    // before the shift, so a negative cross sum borrows from the upper word.
    always_comb begin
        w_product_d = {a_p4_q, a_p1_q}
                    + ({{30{a_cross_q[33]}}, a_cross_q} << 16);
        w_result_d  = a_hi_q ? w_product_d[63:32] : w_product_d[31:0];
    end

    // ---------------------------------------------------------------------
    // Valid bits: flush wins over capture and acts even while stalled.
    // ---------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so
    // stage W samples the pre-edge stage A value, not the one loaded on the
    // same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            w_valid_q <= 1'b0;
        end else if (flush) begin
            a_valid_q <= 1'b0;
            w_valid_q <= 1'b0;
        end else if (M_en) begin
            a_valid_q <= M_mul_valid;
            w_valid_q <= a_valid_q;
        end
    end

    // ---------------------------------------------------------------------
    // Data registers: load on every enabled edge, whether or not the slot
    // is valid. Consumers qualify with W_mul_valid. Flush does not touch
    // these registers.
    // ---------------------------------------------------------------------
    // NOTE: the data path is reset as well, so the outputs read zero during
    // and after reset instead of stale products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_cross_q   <= '0;
            a_p1_q      <= '0;
            a_p4_q      <= '0;
            a_hi_q      <= 1'b0;
            a_dst_q     <= '0;
            w_product_q <= '0;
            w_result_q  <= '0;
            w_dst_q     <= '0;
        end else if (M_en) begin
            a_cross_q   <= a_cross_d;
            a_p1_q      <= M_mul_cell_p1;
            a_p4_q      <= M_mul_cell_p4;
            a_hi_q      <= M_mul_hi;
            a_dst_q     <= M_dst_regnum;
            w_product_q <= w_product_d;
            w_result_q  <= w_result_d;
            w_dst_q     <= a_dst_q;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign W_mul_valid   = w_valid_q;
    assign W_mul_result  = w_result_q;
    assign W_mul_product = w_product_q;
    assign W_dst_regnum  = w_dst_q;
    assign mul_busy      = a_valid_q | w_valid_q;

endmodule

// File: tb/tb_nios2_mul_combine.sv
// -----------------------------------------------------------------------------
// tb_nios2_mul_combine
//
// Directed bench for nios2_mul_combine. Inputs change 1 ns after each rising
// edge, and outputs are sampled at that same point, well clear of the next
// edge. All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_nios2_mul_combine;

    localparam int REGNUM_W = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                M_en;
    logic                flush;
    logic                M_mul_valid;
    logic                M_mul_src1_signed;
    logic                M_mul_src2_signed;
    logic                M_mul_hi;
    logic [REGNUM_W-1:0] M_dst_regnum;
    logic [31:0]         M_mul_cell_p1;
    logic [31:0]         M_mul_cell_p2;
    logic [31:0]         M_mul_cell_p3;
    logic [31:0]         M_mul_cell_p4;
    logic                W_mul_valid;
    logic [31:0]         W_mul_result;
    logic [63:0]         W_mul_product;
    logic [REGNUM_W-1:0] W_dst_regnum;
    logic                mul_busy;

    int n_vec = 0;
    int n_mis = 0;

    nios2_mul_combine #(.REGNUM_W(REGNUM_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .M_en              (M_en),
        .flush             (flush),
        .M_mul_valid       (M_mul_valid),
        .M_mul_src1_signed (M_mul_src1_signed),
        .M_mul_src2_signed (M_mul_src2_signed),
        .M_mul_hi          (M_mul_hi),
        .M_dst_regnum      (M_dst_regnum),
        .M_mul_cell_p1     (M_mul_cell_p1),
        .M_mul_cell_p2     (M_mul_cell_p2),
        .M_mul_cell_p3     (M_mul_cell_p3),
        .M_mul_cell_p4     (M_mul_cell_p4),
        .W_mul_valid       (W_mul_valid),
        .W_mul_result      (W_mul_result),
        .W_mul_product     (W_mul_product),
        .W_dst_regnum      (W_dst_regnum),
        .mul_busy          (mul_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic s1, input logic s2, input logic hi,
                           input logic [REGNUM_W-1:0] dst,
                           input logic [31:0] p1, input logic [31:0] p2,
                           input logic [31:0] p3, input logic [31:0] p4);
        M_mul_valid       = v;
        M_mul_src1_signed = s1;
        M_mul_src2_signed = s2;
        M_mul_hi          = hi;
        M_dst_regnum      = dst;
        M_mul_cell_p1     = p1;
        M_mul_cell_p2     = p2;
        M_mul_cell_p3     = p3;
        M_mul_cell_p4     = p4;
    endtask

    task automatic idle();
        present(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    // Present one multiply and check it arrives exactly two edges later.
    task automatic run_one(input string tag, input logic s1, input logic s2, input logic hi,
                           input logic [REGNUM_W-1:0] dst,
                           input logic [31:0] p1, input logic [31:0] p2,
                           input logic [31:0] p3, input logic [31:0] p4,
                           input logic [63:0] exp_prod, input logic [31:0] exp_res);
        present(1'b1, s1, s2, hi, dst, p1, p2, p3, p4);
        tick();
        idle();
        check({tag, "_early_valid"}, 64'(W_mul_valid), 64'd0);
        tick();
        check({tag, "_valid"},   64'(W_mul_valid),   64'd1);
        check({tag, "_product"}, W_mul_product,      exp_prod);
        check({tag, "_result"},  64'(W_mul_result),  64'(exp_res));
        check({tag, "_dst"},     64'(W_dst_regnum),  64'(dst));
        tick();
        check({tag, "_valid_drop"}, 64'(W_mul_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        M_en  = 1'b1;
        flush = 1'b0;
        idle();
        tick();
        tick();

        // Reset state.
        check("rst_valid",   64'(W_mul_valid),  64'd0);
        check("rst_result",  64'(W_mul_result), 64'd0);
        check("rst_product", W_mul_product,     64'd0);
        check("rst_dst",     64'(W_dst_regnum), 64'd0);
        check("rst_busy",    64'(mul_busy),     64'd0);
        reset = 1'b0;
        tick();

        // Signedness combinations.
        run_one("uu_hi", 1'b0, 1'b0, 1'b1, 5'd7,
                32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001,
                64'hFFFFFFFE_00000001, 32'hFFFFFFFE);
        run_one("uu_lo", 1'b0, 1'b0, 1'b0, 5'd8,
                32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001,
                64'hFFFFFFFE_00000001, 32'h00000001);
        run_one("ss_lo", 1'b1, 1'b1, 1'b0, 5'd9,
                32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001,
                64'h00000000_00000001, 32'h00000001);
        run_one("ss_hi", 1'b1, 1'b1, 1'b1, 5'd10,
                32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001,
                64'h00000000_00000001, 32'h00000000);
        run_one("su_hi", 1'b1, 1'b0, 1'b1, 5'd11,
                32'h00000000, 32'h00000000, 32'h80008000, 32'h80008000,
                64'h80000000_80000000, 32'h80000000);

        // Back-to-back: dst k carries product k.
        for (int k = 1; k <= 4; k++) begin
            present(1'b1, 1'b0, 1'b0, 1'b0, 5'(k), 32'(k), '0, '0, '0);
            tick();
            if (k >= 2) begin
                check($sformatf("b2b_valid_%0d", k - 1), 64'(W_mul_valid),  64'd1);
                check($sformatf("b2b_dst_%0d",   k - 1), 64'(W_dst_regnum), 64'(k - 1));
                check($sformatf("b2b_res_%0d",   k - 1), 64'(W_mul_result), 64'(k - 1));
            end
        end
        idle();
        tick();
        check("b2b_valid_4", 64'(W_mul_valid),  64'd1);
        check("b2b_dst_4",   64'(W_dst_regnum), 64'd4);
        check("b2b_res_4",   64'(W_mul_result), 64'd4);
        tick();
        check("b2b_drain", 64'(W_mul_valid), 64'd0);

        // Stall mid-stream: m1 in W, m2 in A, hold for 3 cycles.
        present(1'b1, 1'b0, 1'b0, 1'b0, 5'd20, 32'd20, '0, '0, '0);
        tick();
        present(1'b1, 1'b0, 1'b0, 1'b0, 5'd21, 32'd21, '0, '0, '0);
        tick();
        idle();
        M_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("stall_valid_%0d", s), 64'(W_mul_valid),  64'd1);
            check($sformatf("stall_dst_%0d",   s), 64'(W_dst_regnum), 64'd20);
            check($sformatf("stall_res_%0d",   s), 64'(W_mul_result), 64'd20);
            check($sformatf("stall_busy_%0d",  s), 64'(mul_busy),     64'd1);
        end
        M_en = 1'b1;
        tick();
        check("stall_m2_valid", 64'(W_mul_valid),  64'd1);
        check("stall_m2_dst",   64'(W_dst_regnum), 64'd21);
        check("stall_m2_res",   64'(W_mul_result), 64'd21);
        tick();
        check("stall_drain", 64'(W_mul_valid), 64'd0);

        // Flush while stalled: the multiply in A never reaches W.
        present(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'd3, '0, '0, '0);
        tick();
        check("fl_a_busy", 64'(mul_busy), 64'd1);
        idle();
        M_en  = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        M_en  = 1'b1;
        check("fl_busy", 64'(mul_busy),    64'd0);
        check("fl_w0",   64'(W_mul_valid), 64'd0);
        tick();
        check("fl_w1", 64'(W_mul_valid), 64'd0);
        tick();
        check("fl_w2", 64'(W_mul_valid), 64'd0);

        // Flush together with a new multiply: it is dropped.
        present(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'd5, '0, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("flnew_busy", 64'(mul_busy), 64'd0);
        tick();
        check("flnew_w", 64'(W_mul_valid), 64'd0);

        // Async reset between edges with both stages valid.
        present(1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 32'hFFFE0001, 32'hFFFE0001,
                32'hFFFE0001, 32'hFFFE0001);
        tick();
        tick();
        idle();
        check("ar_pre_busy",  64'(mul_busy),    64'd1);
        check("ar_pre_valid", 64'(W_mul_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid",   64'(W_mul_valid),  64'd0);
        check("ar_busy",    64'(mul_busy),     64'd0);
        check("ar_result",  64'(W_mul_result), 64'd0);
        check("ar_product", W_mul_product,     64'd0);
        #1;
        reset = 1'b0;
        tick();

        // After release: 3*5 unsigned.
        run_one("post_rst", 1'b0, 1'b0, 1'b0, 5'd2,
                32'h0000000F, '0, '0, '0,
                64'h00000000_0000000F, 32'h0000000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/nios2_mul_combine.md
# nios2_mul_combine

Pipelined partial-product combiner for the Nios II multiply path. It sits directly downstream of the four-cell 16x16 multiplier array. It takes the four registered 32-bit partial products (p1 = lo*lo, p2 = lo1*hi2, p3 = hi1*lo2, p4 = hi*hi), applies the per-operand signedness, and produces the full 64-bit product over two pipeline stages. It returns the low word (MUL) or the high word (MULXSS/MULXSU/MULXUU) with the destination register number, sustaining one multiply per enabled cycle.

## Interface
- REGNUM_W, 5, destination register number width
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- M_en  in  1  pipeline advance enable; 0 = stall, hold every register
- flush  in  1  synchronous kill of all in-flight multiplies
- M_mul_valid  in  1  p1..p4 hold a multiply this cycle
- M_mul_src1_signed  in  1  src1 treated as signed
- M_mul_src2_signed  in  1  src2 treated as signed
- M_mul_hi  in  1  1 = return product[63:32], 0 = product[31:0]
- M_dst_regnum  in  REGNUM_W  destination register
- M_mul_cell_p1  in  32  src1[15:0]*src2[15:0], unsigned
- M_mul_cell_p2  in  32  src1[15:0]*src2[31:16], signed iff src2_signed
- M_mul_cell_p3  in  32  src1[31:16]*src2[15:0], signed iff src1_signed
- M_mul_cell_p4  in  32  src1[31:16]*src2[31:16], signed iff either signed
- W_mul_valid  out  1  W_mul_result valid
- W_mul_result  out  32  selected product word
- W_mul_product  out  64  full product, for debug/trace
- W_dst_regnum  out  REGNUM_W  destination register
- mul_busy  out  1  A_valid | W_valid

## Operation
- Stage A, captured when M_en=1:
  - A_valid <= M_mul_valid & ~flush.
  - A_cross (34b signed) <= ext34(p2, src2_signed) + ext34(p3, src1_signed). ext = sign-extend if flag, else zero-extend.
  - A_p1 <= p1.
  - A_p4 <= p4.
  - A_p4_signed <= src1_signed | src2_signed.
  - A_hi <= M_mul_hi; A_dst <= M_dst_regnum.
- Stage W, captured when M_en=1:
  - W_valid <= A_valid & ~flush.
  - W_mul_product <= {ext32(A_p4, A_p4_signed), A_p1} + (sext64(A_cross) << 16), mod 2^64.
  - W_mul_result <= A_hi ? product[63:32] : product[31:0].
  - W_dst_regnum <= A_dst.
- Data registers load whenever M_en=1, regardless of valid. Consumers qualify with W_mul_valid only.
- flush=1 clears A_valid and W_valid at the next edge even when M_en=0. flush takes priority over capture. Data registers are unaffected by flush.
- Stall: M_en=0 and flush=0 hold all registers, outputs included.
- Reset values: every register 0. So W_mul_valid=0, W_mul_result=0, W_mul_product=0, W_dst_regnum=0, mul_busy=0.
- Arithmetic is exact for all four signedness combos. p4 for the uu case can reach 0xFFFE0001 and must be zero-extended.

## Timing
- Latency: 2 enabled edges from the M-stage cycle to W output.
  - Multiply presented in cycle N with M_en=1.
  - W_mul_valid=1 throughout cycle N+2, assuming M_en=1 in N and N+1.
- Each stall cycle adds one cycle of latency per stalled stage. Ordering is preserved.
- Throughput: one multiply per enabled cycle. Back-to-back valids produce back-to-back W_mul_valid.
- Reset asserted mid-operation: all valids drop within the same cycle, with no clock needed. The first capture after deassertion is at the next M_en edge.
- flush and M_mul_valid in the same cycle: the new multiply is discarded.
- Critical path: 64-bit add in stage W. Stage A holds only the 34-bit cross add.

## Test plan
- uu, src1=src2=0xFFFFFFFF: p1..p4=0xFFFE0001. Expect product 0xFFFFFFFE00000001; hi=1 -> 0xFFFFFFFE, hi=0 -> 0x00000001; valid exactly 2 cycles after input.
- ss, src1=src2=0xFFFFFFFF: p1=0xFFFE0001, p2=p3=0xFFFF0001, p4=0x00000001. Expect product 0x0000000000000001.
- su, src1=0x80000000 signed, src2=0xFFFFFFFF unsigned: p1=p2=0, p3=p4=0x80008000. Expect product 0x8000000080000000, hi result 0x80000000.
- Back-to-back: 4 consecutive multiplies with dst 1..4 -> 4 consecutive W_mul_valid cycles, correct dst order. Then insert M_en=0 for 3 cycles mid-stream -> outputs held, nothing lost or duplicated.
- Flush: multiply in A with flush=1 and M_en=0 -> W_mul_valid never asserts for it; mul_busy=0 next cycle. flush together with a new M_mul_valid -> that multiply dropped.
- Async reset: assert reset between edges while both stages are valid -> W_mul_valid, mul_busy, W_mul_result and W_mul_product read 0 immediately. After release, a new 3*5 uu multiply -> 0x0000000F.
